// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, bus widths and constants for the
// IF/MEM single-port memory arbiter (mem_ctrl) and its watchdog timer.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned TIMER_W = 8;

  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = 32'h0000_0000;
  localparam logic [SEL_W-1:0]  SEL_FULL  = 4'b1111;
  localparam logic [SEL_W-1:0]  SEL_NONE  = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  // True while an access is outstanding on the external port.
  function automatic logic is_wait(input state_e s);
    return (s == ST_IF_WAIT) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/mem_ctrl_timer.sv
// mem_ctrl_timer: watchdog for an outstanding external access. Only built
// when MEM_CTRL_TIMEOUT_EN is defined. The count is cleared when an access
// is launched and advances every waiting cycle without an acknowledge;
// expire_o flags the last allowed waiting cycle.
`ifdef MEM_CTRL_TIMEOUT_EN
module mem_ctrl_timer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: clear on launch, saturate at the last waiting cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {TIMER_W{1'b0}};
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {TIMER_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i & (count_q == LAST);

endmodule
`endif

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port memory controller/arbiter between the IF stage
// (read-only fetch) and the MEM stage (load/store). MEM has fixed priority.
// Each access runs IDLE -> *_WAIT -> RESP; the owner gets a one-cycle done
// pulse in RESP. Optional watchdog: define MEM_CTRL_TIMEOUT_EN to abort an
// access that is not acknowledged within TIMEOUT_CYCLES waiting cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_re_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_busy_o,
  output logic              if_done_o,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_busy_o,
  output logic              mem_done_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  input  logic              ram_ack_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              err_o
);

  state_e            state_q,     state_d;
  logic              ram_req_q,   ram_req_d;
  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [SEL_W-1:0]  ram_sel_q,   ram_sel_d;
  logic [DATA_W-1:0] if_data_q,   if_data_d;
  logic [DATA_W-1:0] mem_data_q,  mem_data_d;
  logic              if_done_q,   if_done_d;
  logic              mem_done_q,  mem_done_d;
  logic              err_q,       err_d;

  logic wait_s;
  logic mem_req_s;
  logic timer_clear_s;
  logic timer_expire_s;

  assign wait_s    = is_wait(state_q);
  assign mem_req_s = mem_re_i | mem_we_i;

`ifdef MEM_CTRL_TIMEOUT_EN
  mem_ctrl_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear_s),
    .enable_i (wait_s & ~ram_ack_i),
    .expire_o (timer_expire_s)
  );
`else
  // Without the watchdog an access waits for its acknowledge indefinitely.
  logic [TIMER_W:0] unused_timeout_s;
  assign unused_timeout_s = {timer_clear_s, TIMER_W'(TIMEOUT_CYCLES)};
  assign timer_expire_s   = 1'b0;
`endif

  // Arbitration, port-field latching, read-data capture and done/err decode.
  always_comb begin
    state_d       = state_q;
    ram_req_d     = 1'b0;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_sel_d     = ram_sel_q;
    if_data_d     = if_data_q;
    mem_data_d    = mem_data_q;
    if_done_d     = 1'b0;
    mem_done_d    = 1'b0;
    err_d         = 1'b0;
    timer_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_s) begin
          state_d       = ST_MEM_WAIT;
          ram_req_d     = 1'b1;
          ram_we_d      = mem_we_i;
          ram_addr_d    = mem_addr_i;
          ram_wdata_d   = mem_wdata_i;
          ram_sel_d     = mem_sel_i;
          timer_clear_s = 1'b1;
        end else if (if_re_i) begin
          state_d       = ST_IF_WAIT;
          ram_req_d     = 1'b1;
          ram_we_d      = 1'b0;
          ram_addr_d    = if_addr_i;
          ram_sel_d     = SEL_FULL;
          timer_clear_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IF_WAIT, ST_MEM_WAIT: begin
        if (ram_ack_i) begin
          // An acknowledge in the expiry cycle still completes normally.
          state_d = ST_RESP;
          if (state_q == ST_IF_WAIT) begin
            if_data_d = ram_rdata_i;
            if_done_d = 1'b1;
          end else begin
            mem_done_d = 1'b1;
            if (!ram_we_q) begin
              mem_data_d = ram_rdata_i;
            end else begin
              mem_data_d = mem_data_q;
            end
          end
        end else if (timer_expire_s) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          if (state_q == ST_IF_WAIT) begin
            if_data_d = ZERO_WORD;
            if_done_d = 1'b1;
          end else begin
            mem_data_d = ZERO_WORD;
            mem_done_d = 1'b1;
          end
        end else begin
          state_d   = state_q;
          ram_req_d = 1'b1;
        end
      end
      ST_RESP: begin
        // Requests are not sampled here; a held request restarts from IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= ZERO_ADDR;
      ram_wdata_q <= ZERO_WORD;
      ram_sel_q   <= SEL_NONE;
      if_data_q   <= ZERO_WORD;
      mem_data_q  <= ZERO_WORD;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_sel_q   <= ram_sel_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      err_q       <= err_d;
    end
  end

  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_sel_o   = ram_sel_q;
  assign if_data_o   = if_data_q;
  assign mem_data_o  = mem_data_q;
  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign err_o       = err_q;

  // MEM always outranks IF, so IF is also blocked by a pending MEM request.
  assign mem_busy_o = (state_q != ST_IDLE);
  assign if_busy_o  = (state_q != ST_IDLE) | mem_req_s;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Requests push their expected
// response into per-requester queues; a monitor pops on each done pulse.
// A behavioural RAM answers the external port with random latency.
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_re_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_busy_o, if_done_o;
  logic        mem_re_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_o;
  logic        mem_busy_o, mem_done_o;
  logic        ram_req_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [3:0]  ram_sel_o;
  logic        ram_ack_i;
  logic [31:0] ram_rdata_i;
  logic        err_o;

  mem_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_re_i(if_re_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_busy_o(if_busy_o), .if_done_o(if_done_o),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i), .mem_data_o(mem_data_o),
    .mem_busy_o(mem_busy_o), .mem_done_o(mem_done_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_sel_o(ram_sel_o),
    .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic is_load; logic err; logic [31:0] data; } exp_t;
  typedef struct packed { logic we; logic [31:0] addr; } acc_t;

  exp_t        if_q[$];
  exp_t        mem_q[$];
  acc_t        acc_log[$];
  logic [31:0] mem_ref[int];
  logic [31:0] ram_mem[int];
  logic [31:0] last_if  = 32'h0;
  logic [31:0] last_mem = 32'h0;
  int          if_done_cnt  = 0;
  int          mem_done_cnt = 0;

  // IF fetches use 0x100..0x17C (read-only), MEM uses 0x200..0x23C.
  function automatic bit in_if_region(input logic [31:0] a);
    return (a >= 32'h100) && (a < 32'h180);
  endfunction

  function automatic logic [31:0] if_word(input logic [31:0] a);
    return 32'h0000_0013 + ((a - 32'h100) << 8);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int w;
    w = int'(a >> 2);
    if (mem_ref.exists(w)) return mem_ref[w];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    int w;
    w = int'(a >> 2);
    if (in_if_region(a)) return if_word(a);
    if (ram_mem.exists(w)) return ram_mem[w];
    return 32'h0;
  endfunction

  // ---------------- behavioural external RAM ----------------
  bit          resp_en = 1'b1;
  int          resp_dly_fixed = -1;
  logic        manual_ack = 1'b0;
  logic [31:0] manual_rdata = 32'h0;

  initial begin : responder
    int left;
    left = -1;
    ram_ack_i   = 1'b0;
    ram_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        left        = -1;
        ram_ack_i   = manual_ack;
        ram_rdata_i = manual_rdata;
      end else begin
        ram_ack_i   = 1'b0;
        ram_rdata_i = $urandom();
        if (ram_req_o) begin
          if (left < 0)
            left = (resp_dly_fixed >= 0) ? resp_dly_fixed : int'($urandom_range(0, 3));
          if (left == 0) begin
            left = -1;
            ram_ack_i = 1'b1;
            acc_log.push_back('{we: ram_we_o, addr: ram_addr_o});
            if (in_if_region(ram_addr_o)) begin
              check("if_port_we", 32'(ram_we_o), 32'd0);
              check("if_port_sel", 32'(ram_sel_o), 32'hF);
            end
            if (ram_we_o)
              ram_mem[int'(ram_addr_o >> 2)] = merge(ram_rd(ram_addr_o), ram_wdata_o, ram_sel_o);
            else
              ram_rdata_i = ram_rd(ram_addr_o);
          end else begin
            left--;
          end
        end else begin
          left = -1;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (if_done_o && mem_done_o) check("dual_done", 32'(if_done_o & mem_done_o), 32'd0);
      if (if_done_o) begin
        if_done_cnt++;
        if (if_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL if_spurious_done: got pulse, expected none (data 0x%08h)", if_data_o);
        end else begin
          e = if_q.pop_front();
          check("if_data", if_data_o, e.data);
          check("if_err", 32'(err_o), 32'(e.err));
          last_if = e.data;
        end
      end
      if (mem_done_o) begin
        mem_done_cnt++;
        if (mem_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mem_spurious_done: got pulse, expected none (data 0x%08h)", mem_data_o);
        end else begin
          e = mem_q.pop_front();
          check("mem_err", 32'(err_o), 32'(e.err));
          if (e.is_load || e.err) last_mem = e.data;
          check(e.is_load ? "mem_load_data" : "mem_data_hold_on_store", mem_data_o, last_mem);
        end
      end
    end
  end

  // ---------------- request drivers ----------------
  task automatic wait_done(input bit is_if, output int lat);
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      lat++;
      if (is_if ? if_done_o : mem_done_o) return;
    end
    n_tests++; n_fail++;
    $display("FAIL %s_done_timeout: got no done after %0d cycles, expected a pulse",
             is_if ? "if" : "mem", lat);
  endtask

  task automatic if_txn(input logic [31:0] a, output int lat);
    @(negedge clk);
    if_re_i   = 1'b1;
    if_addr_i = a;
    if_q.push_back('{is_load: 1'b1, err: 1'b0, data: if_word(a)});
    wait_done(1'b1, lat);
  endtask

  task automatic mem_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] sel, output int lat);
    @(negedge clk);
    mem_re_i    = ~we;
    mem_we_i    = we;
    mem_addr_i  = a;
    mem_wdata_i = wd;
    mem_sel_i   = sel;
    if (we) begin
      mem_ref[int'(a >> 2)] = merge(ref_rd(a), wd, sel);
      mem_q.push_back('{is_load: 1'b0, err: 1'b0, data: 32'h0});
    end else begin
      mem_q.push_back('{is_load: 1'b1, err: 1'b0, data: ref_rd(a)});
    end
    wait_done(1'b0, lat);
  endtask

  task automatic if_idle();
    @(negedge clk);
    if_re_i = 1'b0;
  endtask

  task automatic mem_idle();
    @(negedge clk);
    mem_re_i = 1'b0;
    mem_we_i = 1'b0;
  endtask

  // ---------------- global time bound ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, lat_m, lat_i, n0, req_hi;
    rst = 1'b1;
    if_re_i = 1'b0; if_addr_i = 32'h0;
    mem_re_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0; mem_sel_i = 4'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_req", 32'(ram_req_o), 32'd0);
    check("rst_ram_we", 32'(ram_we_o), 32'd0);
    check("rst_ram_addr", ram_addr_o, 32'h0);
    check("rst_ram_wdata", ram_wdata_o, 32'h0);
    check("rst_ram_sel", 32'(ram_sel_o), 32'd0);
    check("rst_dones_err", 32'({if_done_o, mem_done_o, err_o}), 32'd0);
    check("rst_if_data", if_data_o, 32'h0);
    check("rst_mem_data", mem_data_o, 32'h0);
    check("rst_busy", 32'({if_busy_o, mem_busy_o}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // IF fetch at 0x100, ack one cycle after ram_req_o: done three cycles out.
    resp_dly_fixed = 1;
    if_txn(32'h100, lat);
    check("if_latency_ack_plus1", 32'(lat), 32'd3);
    if_idle();

    // Minimum latency MEM load.
    resp_dly_fixed = 0;
    mem_txn(1'b0, 32'h20C, 32'h0, 4'hF, lat);
    check("mem_min_latency", 32'(lat), 32'd2);
    mem_idle();
    repeat (2) @(negedge clk);

    // Simultaneous IF fetch and MEM store: MEM first, IF blocked meanwhile.
    acc_log.delete();
    fork
      begin mem_txn(1'b1, 32'h200, 32'hDEADBEEF, 4'b0011, lat_m); mem_idle(); end
      begin if_txn(32'h104, lat_i); if_idle(); end
      begin
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          check("if_busy_during_mem", 32'(if_busy_o), 32'd1);
          if (mem_done_o) break;
        end
      end
    join
    check("arb_mem_latency", 32'(lat_m), 32'd2);
    check("arb_if_latency", 32'(lat_i), 32'd5);
    check("arb_access_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) begin
      check("arb_first_is_store", {acc_log[0].we, acc_log[0].addr[30:0]}, 32'h8000_0200);
      check("arb_second_is_fetch", {acc_log[1].we, acc_log[1].addr[30:0]}, 32'h0000_0104);
    end

    // Back-to-back MEM loads with the request held through RESP.
    acc_log.delete();
    n0 = mem_done_cnt;
    mem_txn(1'b0, 32'h200, 32'h0, 4'hF, lat);
    mem_txn(1'b0, 32'h204, 32'h0, 4'hF, lat);
    check("b2b_second_latency", 32'(lat), 32'd3);
    mem_idle();
    repeat (4) @(negedge clk);
    check("b2b_access_count", 32'(acc_log.size()), 32'd2);
    check("b2b_done_count", 32'(mem_done_cnt - n0), 32'd2);

    // Spurious acknowledge while IDLE.
    resp_en = 1'b0;
    @(posedge clk); #2;
    manual_ack = 1'b1; manual_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("spur_no_done", 32'({if_done_o, mem_done_o}), 32'd0);
      check("spur_if_data_hold", if_data_o, last_if);
      check("spur_mem_data_hold", mem_data_o, last_mem);
    end
    manual_ack = 1'b0;

    // Reset during MEM_WAIT; the late acknowledge must be discarded.
    @(negedge clk);
    mem_re_i = 1'b1; mem_addr_i = 32'h210; mem_sel_i = 4'hF;
    @(posedge clk); #1;
    check("rstmid_req_before", 32'(ram_req_o), 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_re_i = 1'b0;
    @(posedge clk); #1;
    check("rstmid_req_after", 32'(ram_req_o), 32'd0);
    manual_ack = 1'b1; manual_rdata = 32'h5555_AAAA;
    @(negedge clk);
    rst = 1'b0;
    last_if = 32'h0; last_mem = 32'h0;
    @(posedge clk); #1;
    check("rstmid_no_done", 32'(mem_done_o), 32'd0);
    check("rstmid_idle", 32'({ram_req_o, mem_busy_o}), 32'd0);
    check("rstmid_mem_data", mem_data_o, 32'h0);
    manual_ack = 1'b0;
    @(negedge clk);

`ifdef MEM_CTRL_TIMEOUT_EN
    // Watchdog: no acknowledge at all.
    if_re_i = 1'b1; if_addr_i = 32'h108;
    if_q.push_back('{is_load: 1'b1, err: 1'b1, data: 32'h0});
    lat = 0; req_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (if_done_o) break;
      req_hi += int'(ram_req_o);
    end
    check("tmo_req_cycles", 32'(req_hi), 32'(TB_TIMEOUT));
    check("tmo_latency", 32'(lat), 32'(TB_TIMEOUT + 1));
    if_idle();
`else
    req_hi = 0;
`endif
    resp_en = 1'b1;
    resp_dly_fixed = -1;

    // Randomised traffic from both requesters.
    fork
      begin
        int l, g;
        for (int k = 0; k < 30; k++) begin
          if_txn(32'h100 + 32'($urandom_range(0, 31)) * 32'd4, l);
          g = int'($urandom_range(0, 3));
          if (g > 0) begin
            if_idle();
            repeat (g) @(negedge clk);
          end
        end
        if_idle();
      end
      begin
        int l, g;
        logic [31:0] a;
        for (int k = 0; k < 30; k++) begin
          a = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
          mem_txn(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(1, 15)), l);
          g = int'($urandom_range(0, 3));
          if (g > 0) begin
            mem_idle();
            repeat (g) @(negedge clk);
          end
        end
        mem_idle();
      end
    join

    repeat (8) @(negedge clk);
    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
